// File: rtl/tap_apb_master.sv
// APB3 master stage behind the JTAG TAP: turns a one-cycle TAP request into an APB transfer and reports DONE/DATA/FAIL.
// Optional PREADY timeout is built only when TAP_APB_TIMEOUT_EN is defined.
module tap_apb_master #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ERR_WIDTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = 32'h0001_0000,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                  TCK,
    input  logic                  TRST_n,
    input  logic                  TRANSFER_tap_apb,
    input  logic                  RorW_tap_apb,
    input  logic [ADDR_WIDTH-1:0] ADDR_tap_apb,
    input  logic [DATA_WIDTH-1:0] DATA_tap_apb,
    output logic [DATA_WIDTH-1:0] DATA_apb_tap,
    output logic [ERR_WIDTH-1:0]  FAIL_apb_tap,
    output logic                  DONE_apb_tap,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [ERR_WIDTH-1:0] ERR_OK      = ERR_WIDTH'(0);
    localparam logic [ERR_WIDTH-1:0] ERR_INVALID = ERR_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0] ERR_SLVERR  = ERR_WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

    // One extra bit on both sides so BASE_ADDR+ADDR_SPAN cannot wrap past the top of the address space.
    logic [ADDR_WIDTH:0] addr_ext;
    logic [ADDR_WIDTH:0] lo_bound;
    logic [ADDR_WIDTH:0] hi_bound;
    logic                addr_ok;

    assign addr_ext = {1'b0, ADDR_tap_apb};
    assign lo_bound = {1'b0, BASE_ADDR};
    assign hi_bound = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};
    assign addr_ok  = (addr_ext >= lo_bound) && (addr_ext < hi_bound);

`ifdef TAP_APB_TIMEOUT_EN
    localparam logic [ERR_WIDTH-1:0] ERR_TIMEOUT = ERR_WIDTH'(3);
    localparam int                   CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            state        <= IDLE;
            DATA_apb_tap <= '0;
            FAIL_apb_tap <= '0;
            DONE_apb_tap <= 1'b0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
`ifdef TAP_APB_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    DONE_apb_tap <= 1'b0;
                    if (TRANSFER_tap_apb) begin
                        if (addr_ok) begin
                            PADDR   <= ADDR_tap_apb;
                            PWRITE  <= RorW_tap_apb;
                            PWDATA  <= RorW_tap_apb ? DATA_tap_apb : '0;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            state   <= SETUP;
                        end else begin
                            // Out-of-window requests complete without touching the bus.
                            FAIL_apb_tap <= ERR_INVALID;
                            DATA_apb_tap <= '0;
                            DONE_apb_tap <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef TAP_APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL         <= 1'b0;
                        PENABLE      <= 1'b0;
                        FAIL_apb_tap <= PSLVERR ? ERR_SLVERR : ERR_OK;
                        DATA_apb_tap <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                        DONE_apb_tap <= 1'b1;
                        state        <= RESP;
                    end
`ifdef TAP_APB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        PSEL         <= 1'b0;
                        PENABLE      <= 1'b0;
                        FAIL_apb_tap <= ERR_TIMEOUT;
                        DATA_apb_tap <= '0;
                        DONE_apb_tap <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    DONE_apb_tap <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    DONE_apb_tap <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
